// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC scanning voltmeter.
//   ADC_CODE_W  : width of a stored conversion code
//   DRP_ADDR_W  : width of a DRP register address
//   OVR_THRESH  : codes at or above this value are reported as full scale
//   scan_state_t: DRP read sequencer states
package xadc_pkg;
   localparam int ADC_CODE_W = 12;
   localparam int DRP_ADDR_W = 7;
   localparam logic [ADC_CODE_W-1:0] OVR_THRESH = 12'd4093;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } scan_state_t;
endpackage

// File: rtl/xadc_scan_dmm_bin2bcd_seq.sv
// Iterative double-dabble binary to BCD converter, one input bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load bin and begin (ignored while busy)
//   bin        : unsigned binary input
//   busy       : conversion in progress
//   done       : one-cycle pulse, bcd updated in the same cycle
//   bcd        : registered result, digit 0 in LSBs
module bin2bcd_seq #(
   parameter int BIN_W      = 20,
   parameter int NUM_DIGITS = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [BIN_W-1:0]        bin,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd
);
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = 4 * NUM_DIGITS;

   logic [BIN_W-1:0] r_sh;
   logic [BCD_W-1:0] r_acc;
   logic [BCD_W-1:0] r_bcd;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [BCD_W-1:0] w_adj;
   logic [BCD_W-1:0] w_acc_nxt;

   function automatic logic [BCD_W-1:0] f_add3(input logic [BCD_W-1:0] a);
      logic [BCD_W-1:0] r;
      r = a;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      return r;
   endfunction

   assign w_adj     = f_add3(r_acc);
   assign w_acc_nxt = {w_adj[BCD_W-2:0], r_sh[BIN_W-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_cnt  <= '0;
         r_bcd  <= '0;
      end else begin
         r_done <= 1'b0;
         if (start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(BIN_W);
         end else if (r_busy) begin
            r_cnt <= r_cnt - 1'b1;
            // Last iteration writes the finished value straight to the output.
            if (r_cnt == CNT_W'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_bcd  <= w_acc_nxt;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start && !r_busy) begin
         r_sh  <= bin;
         r_acc <= '0;
      end else if (r_busy) begin
         r_sh  <= {r_sh[BIN_W-2:0], 1'b0};
         r_acc <= w_acc_nxt;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign bcd  = r_bcd;
endmodule

// File: rtl/xadc_scan_dmm.sv
// Multi-channel XADC voltmeter: round-robin DRP reads, per-channel code store,
// periodic microvolt scaling and BCD conversion of the selected channel.
//   CLK100MHZ, CPU_RESETN : clock, asynchronous active-low reset
//   eoc_in, drdy_in, do_in: XADC end-of-conversion and DRP read return
//   daddr_out, den_out    : DRP read request
//   sel, hold             : displayed channel, display freeze
//   ch_valid, sample_out  : channels read so far, live code of channel sel
//   digits_out/_valid     : BCD microvolts and update pulse
//   overrange, drp_timeout: last conversion clamped, sticky DRP read timeout
module xadc_scan_dmm
   import xadc_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter logic [DRP_ADDR_W*NUM_CH-1:0] CH_ADDR_LIST = {7'h1b, 7'h1a, 7'h13, 7'h12},
   parameter int CLK_HZ        = 100_000_000,
   parameter int REFRESH_HZ    = 10,
   parameter int FULL_SCALE_UV = 1_000_000,
   parameter int NUM_DIGITS    = 7,
   parameter int DRDY_TIMEOUT  = 255,
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    CLK100MHZ,
   input  logic                    CPU_RESETN,
   input  logic                    eoc_in,
   input  logic                    drdy_in,
   input  logic [15:0]             do_in,
   output logic [DRP_ADDR_W-1:0]   daddr_out,
   output logic                    den_out,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    hold,
   output logic [NUM_CH-1:0]       ch_valid,
   output logic [ADC_CODE_W-1:0]   sample_out,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic                    digits_valid,
   output logic                    overrange,
   output logic                    drp_timeout
);
   localparam int BIN_W  = $clog2(FULL_SCALE_UV + 1);
   localparam int DIV    = CLK_HZ / REFRESH_HZ;
   localparam int RCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int WCNT_W = (DRDY_TIMEOUT > 1) ? $clog2(DRDY_TIMEOUT) : 1;
   localparam int PROD_W = ADC_CODE_W + BIN_W;
   localparam logic [BIN_W-1:0] FS = BIN_W'(FULL_SCALE_UV);

   scan_state_t             r_state;
   logic [SEL_W-1:0]        r_idx;
   logic                    r_den;
   logic [DRP_ADDR_W-1:0]   r_daddr;
   logic [WCNT_W-1:0]       r_wcnt;
   logic [ADC_CODE_W-1:0]   r_code [NUM_CH];
   logic [NUM_CH-1:0]       r_ch_valid;
   logic                    r_timeout;
   logic [RCNT_W-1:0]       r_rcnt;
   logic                    r_vld_p0;
   logic [ADC_CODE_W-1:0]   r_code_p0;
   logic                    r_ovr_p1;

   logic                    w_tick;
   logic                    w_sel_ok;
   logic                    w_sel_valid;
   logic [ADC_CODE_W-1:0]   w_sample;
   logic                    w_accept;
   logic [BIN_W-1:0]        w_bin;
   logic                    w_busy;
   logic                    w_done;
   logic [4*NUM_DIGITS-1:0] w_bcd;

   // Codes near the top of the range are forced to exactly full scale.
   function automatic logic [BIN_W-1:0] f_scale_sat(input logic [ADC_CODE_W-1:0] c);
      logic [PROD_W-1:0] p;
      p = PROD_W'(c) * PROD_W'(FS);
      if (c >= OVR_THRESH) return FS;
      return p[PROD_W-1:ADC_CODE_W];
   endfunction

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_den      <= 1'b0;
         r_daddr    <= CH_ADDR_LIST[DRP_ADDR_W-1:0];
         r_wcnt     <= '0;
         r_ch_valid <= '0;
         r_timeout  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) r_code[i] <= '0;
      end else begin
         r_den <= 1'b0;
         case (r_state)
            S_IDLE: if (eoc_in) begin
               r_state <= S_REQ;
               r_den   <= 1'b1;
               r_daddr <= CH_ADDR_LIST[DRP_ADDR_W*r_idx +: DRP_ADDR_W];
            end
            S_REQ: begin
               r_state <= S_WAIT;
               r_wcnt  <= '0;
            end
            S_WAIT: if (drdy_in) begin
               r_code[r_idx]     <= do_in[15:4];
               r_ch_valid[r_idx] <= 1'b1;
               r_idx   <= (r_idx == SEL_W'(NUM_CH-1)) ? '0 : r_idx + 1'b1;
               r_state <= S_IDLE;
            end else if (r_wcnt == WCNT_W'(DRDY_TIMEOUT-1)) begin
               // Abandon the read; the same channel is retried on the next eoc.
               r_timeout <= 1'b1;
               r_state   <= S_IDLE;
            end else begin
               r_wcnt <= r_wcnt + 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) r_rcnt <= '0;
      else             r_rcnt <= w_tick ? '0 : r_rcnt + 1'b1;
   end

   assign w_tick   = (r_rcnt == RCNT_W'(DIV-1));
   assign w_sel_ok = ({1'b0, sel} < (SEL_W+1)'(NUM_CH));

   always_comb begin
      w_sample    = '0;
      w_sel_valid = 1'b0;
      if (w_sel_ok) begin
         w_sample    = r_code[sel];
         w_sel_valid = r_ch_valid[sel];
      end
   end

   assign w_accept = w_tick & ~r_vld_p0 & ~w_busy & ~hold & w_sel_valid;

   // Stage 0: latch the selected code on an accepted tick.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_vld_p0 <= 1'b0;
         r_ovr_p1 <= 1'b0;
      end else begin
         r_vld_p0 <= w_accept;
         if (r_vld_p0) r_ovr_p1 <= (r_code_p0 >= OVR_THRESH);
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (w_accept) r_code_p0 <= w_sample;
   end

   // Stage 1: scale to microvolts and hand off to the BCD converter.
   assign w_bin = f_scale_sat(r_code_p0);

   bin2bcd_seq #(
      .BIN_W      (BIN_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bcd (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .start (r_vld_p0),
      .bin   (w_bin),
      .busy  (w_busy),
      .done  (w_done),
      .bcd   (w_bcd)
   );

   assign daddr_out    = r_daddr;
   assign den_out      = r_den;
   assign ch_valid     = r_ch_valid;
   assign sample_out   = w_sample;
   assign digits_out   = w_bcd;
   assign digits_valid = w_done;
   assign overrange    = r_ovr_p1;
   assign drp_timeout  = r_timeout;
endmodule

// File: tb/tb_xadc_scan_dmm.sv
module tb_xadc_scan_dmm;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        eoc_in, drdy_in, hold;
   logic [15:0] do_in;
   logic [1:0]  sel;
   logic [6:0]  daddr_out;
   logic        den_out, digits_valid, overrange, drp_timeout;
   logic [3:0]  ch_valid;
   logic [11:0] sample_out;
   logic [27:0] digits_out;

   always #5 clk = ~clk;

   xadc_scan_dmm #(.CLK_HZ(1000), .REFRESH_HZ(10)) dut (
      .CLK100MHZ(clk), .CPU_RESETN(rst_n), .eoc_in(eoc_in), .drdy_in(drdy_in),
      .do_in(do_in), .daddr_out(daddr_out), .den_out(den_out), .sel(sel),
      .hold(hold), .ch_valid(ch_valid), .sample_out(sample_out),
      .digits_out(digits_out), .digits_valid(digits_valid),
      .overrange(overrange), .drp_timeout(drp_timeout));

   int total = 0;
   int bad = 0;

   // Cycle index since reset release; the refresh tick falls on index%100 == 99.
   int cyc = 0;
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   int          pulses = 0;
   int          dbl = 0;
   int          last_cyc = 0;
   logic [27:0] last_dig = '0;
   logic        last_ovr = 1'b0;
   logic        prev_dv = 1'b0;
   always @(negedge clk) begin
      prev_dv <= digits_valid;
      if (digits_valid) begin
         pulses   <= pulses + 1;
         last_cyc <= cyc;
         last_dig <= digits_out;
         last_ovr <= overrange;
         if (prev_dv) dbl <= dbl + 1;
      end
   end

   // Reference model
   logic [6:0]  addr_m [4] = '{7'h12, 7'h13, 7'h1a, 7'h1b};
   logic [11:0] mcode [4];
   logic [3:0]  mvalid;
   int          midx;

   function automatic logic [27:0] exp_bcd(input logic [11:0] c);
      longint v;
      logic [27:0] r;
      v = (c >= 12'd4093) ? 64'd1000000 : (longint'(c) * 1000000) / 4096;
      r = '0;
      for (int i = 0; i < 7; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mvalid = '0;
      midx = 0;
      for (int i = 0; i < 4; i++) mcode[i] = '0;
   endtask

   task automatic start_req();
      int n;
      @(negedge clk); eoc_in = 1'b1;
      @(negedge clk); eoc_in = 1'b0;
      n = 0;
      while (!den_out && n < 20) begin @(negedge clk); n++; end
      chk("den_seen", {31'd0, den_out}, 32'd1);
      chk("daddr", {25'd0, daddr_out}, {25'd0, addr_m[midx]});
   endtask

   task automatic do_read(input logic [15:0] d, input int dly);
      start_req();
      @(negedge clk);
      chk("den_pulse", {31'd0, den_out}, 32'd0);
      repeat (dly - 1) @(negedge clk);
      drdy_in = 1'b1; do_in = d;
      @(negedge clk);
      drdy_in = 1'b0; do_in = 16'($urandom);
      mcode[midx] = d[15:4];
      mvalid[midx] = 1'b1;
      midx = (midx + 1) % 4;
      chk("ch_valid", {28'd0, ch_valid}, {28'd0, mvalid});
      chk("sample", {20'd0, sample_out}, {20'd0, mcode[sel]});
   endtask

   task automatic wait_pulses(input int k, input int budget);
      int n0, n;
      n0 = pulses;
      n = 0;
      while (pulses < n0 + k && n < budget) begin @(negedge clk); n++; end
      chk("pulse_wait", {31'd0, pulses >= n0 + k}, 32'd1);
   endtask

   task automatic check_conv(input string nm, input int ch);
      chk({nm, "_digits"}, {4'd0, last_dig}, {4'd0, exp_bcd(mcode[ch])});
      chk({nm, "_ovr"}, {31'd0, last_ovr}, {31'd0, mcode[ch] >= 12'd4093});
      chk({nm, "_latency"}, last_cyc % 100, 32'd21);
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_digits"}, {4'd0, digits_out}, 32'd0);
      chk({nm, "_dv"}, {31'd0, digits_valid}, 32'd0);
      chk({nm, "_ovr"}, {31'd0, overrange}, 32'd0);
      chk({nm, "_chv"}, {28'd0, ch_valid}, 32'd0);
      chk({nm, "_sample"}, {20'd0, sample_out}, 32'd0);
      chk({nm, "_to"}, {31'd0, drp_timeout}, 32'd0);
      chk({nm, "_den"}, {31'd0, den_out}, 32'd0);
      chk({nm, "_daddr"}, {25'd0, daddr_out}, 32'h12);
   endtask

   typedef struct {
      logic [15:0] d;
      logic [1:0]  s;
      logic [27:0] ed;
      logic        eo;
   } vec_t;
   vec_t vecs [9];

   logic [15:0] dtmp;
   logic [27:0] d0;
   int          n0, n;

   initial begin
      vecs[0] = '{16'h8000, 2'd0, 28'h0500000, 1'b0};
      vecs[1] = '{16'hFFD0, 2'd1, 28'h1000000, 1'b1};
      vecs[2] = '{16'h0010, 2'd2, 28'h0000244, 1'b0};
      vecs[3] = '{16'hFFC0, 2'd3, 28'h0999023, 1'b0};
      vecs[4] = '{16'hFFFF, 2'd0, 28'h1000000, 1'b1};
      vecs[5] = '{16'h0000, 2'd1, 28'h0000000, 1'b0};
      vecs[6] = '{16'h4000, 2'd2, 28'h0250000, 1'b0};
      vecs[7] = '{16'h0020, 2'd3, 28'h0000488, 1'b0};
      vecs[8] = '{16'hFFE0, 2'd0, 28'h1000000, 1'b1};

      rst_n = 1'b0; eoc_in = 1'b0; drdy_in = 1'b0; do_in = '0; sel = 2'd0; hold = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Scan order across a wrap
      do_read(16'h8000, 3);
      do_read(16'h1230, 3);
      do_read(16'hABC0, 3);
      do_read(16'hFFF0, 3);
      chk("chv_all", {28'd0, ch_valid}, 32'hF);
      do_read(16'h8000, 3);

      // Midscale on channel 0
      wait_pulses(2, 250);
      chk("midscale_digits", {4'd0, last_dig}, 32'h0500000);
      chk("midscale_ovr", {31'd0, last_ovr}, 32'd0);
      chk("midscale_latency", last_cyc % 100, 32'd21);

      // Table vectors: target channel gets the vector code, others random
      for (int v = 0; v < 9; v++) begin
         sel = vecs[v].s;
         for (int k = 0; k < 4; k++) begin
            dtmp = (midx == int'(vecs[v].s)) ? vecs[v].d : 16'($urandom);
            do_read(dtmp, 1 + int'($urandom_range(0, 4)));
         end
         wait_pulses(2, 250);
         chk("vec_digits", {4'd0, last_dig}, {4'd0, vecs[v].ed});
         chk("vec_ovr", {31'd0, last_ovr}, {31'd0, vecs[v].eo});
         chk("vec_latency", last_cyc % 100, 32'd21);
      end

      // Random codes against the model
      for (int r = 0; r < 6; r++) begin
         sel = 2'($urandom_range(0, 3));
         for (int k = 0; k < 4; k++) do_read(16'($urandom), 1 + int'($urandom_range(0, 4)));
         wait_pulses(2, 250);
         check_conv("rand", int'(sel));
      end

      // sel change mid-conversion: the latched channel is reported
      for (int k = 0; k < 4; k++) do_read(16'h1000 * 16'(midx + 1), 3);
      sel = 2'd0;
      n = 0;
      while (cyc % 100 != 5 && n < 120) begin @(negedge clk); n++; end
      sel = 2'd1;
      wait_pulses(1, 100);
      check_conv("selchg_old", 0);
      wait_pulses(1, 150);
      check_conv("selchg_new", 1);

      // Hold freezes display while scanning continues
      hold = 1'b1;
      repeat (30) @(negedge clk);
      n0 = pulses; d0 = digits_out;
      for (int k = 0; k < 4; k++) do_read(16'h0100 * 16'(midx + 3), 3);
      repeat (300) @(negedge clk);
      chk("hold_pulses", pulses, n0);
      chk("hold_digits", {4'd0, digits_out}, {4'd0, d0});
      hold = 1'b0;
      wait_pulses(1, 130);
      check_conv("hold_rel", int'(sel));

      // DRP timeout and retry of the same address
      start_req();
      repeat (250) @(negedge clk);
      chk("to_early", {31'd0, drp_timeout}, 32'd0);
      repeat (10) @(negedge clk);
      chk("to_set", {31'd0, drp_timeout}, 32'd1);
      do_read(16'h7770, 3);
      chk("to_sticky", {31'd0, drp_timeout}, 32'd1);

      // Reset ten cycles into a conversion
      n = 0;
      while (cyc % 100 != 9 && n < 120) begin @(negedge clk); n++; end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      sel = 2'd2;
      n0 = pulses;
      repeat (300) @(negedge clk);
      chk("postrst_pulses", pulses, n0);
      chk("postrst_digits", {4'd0, digits_out}, 32'd0);
      do_read(16'h8000, 3);
      n0 = pulses;
      repeat (300) @(negedge clk);
      chk("invalid_sel_pulses", pulses, n0);
      sel = 2'd0;
      wait_pulses(1, 130);
      check_conv("postrst", 0);

      chk("single_cycle_dv", dbl, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/xadc_scan_dmm.md
Name: xadc_scan_dmm

Overview:
- Parametrised successor to the single-channel XADC voltmeter logic.
- Owns the XADC DRP read side and scans up to NUM_CH channels round-robin, one channel per end-of-conversion.
- Stores the latest 12-bit code for every channel.
- At a fixed refresh rate, converts the selected channel's code to microvolts and then to BCD with a multi-cycle shift-add converter, replacing the single-cycle divide/modulo chain. Output feeds the 7-segment driver and LEDs.

Parameters:
- NUM_CH, 4, number of scanned channels (1..16)
- CH_ADDR_LIST, {7'h1b,7'h1a,7'h13,7'h12}, packed 7*NUM_CH DRP addresses; entry 0 in LSBs
- CLK_HZ, 100_000_000, CLK100MHZ frequency
- REFRESH_HZ, 10, display conversions per second
- FULL_SCALE_UV, 1_000_000, microvolts reported for a full-scale code
- NUM_DIGITS, 7, BCD digits produced
- DRDY_TIMEOUT, 255, cycles to wait for drdy_in before aborting a read

Ports:
- CLK100MHZ  in  1  system clock
- CPU_RESETN  in  1  asynchronous, active-low reset
- eoc_in  in  1  XADC end-of-conversion pulse
- drdy_in  in  1  XADC DRP data ready
- do_in  in  16  XADC DRP read data
- daddr_out  out  7  DRP address
- den_out  out  1  DRP enable, one-cycle pulse
- sel  in  clog2(NUM_CH)  channel shown on the display
- hold  in  1  freeze display; scanning continues
- ch_valid  out  NUM_CH  bit i set once channel i has been read
- sample_out  out  12  latest code of channel sel (combinational mux of stored codes)
- digits_out  out  4*NUM_DIGITS  BCD, digit 0 in LSBs
- digits_valid  out  1  one-cycle pulse when digits_out updates
- overrange  out  1  last conversion was clamped
- drp_timeout  out  1  sticky; cleared only by reset

Behaviour:
Reset values:
- All outputs 0, except daddr_out = CH_ADDR_LIST[0].
- Scan index 0, all stored codes 0, refresh counter 0.
- Reset asserted mid-read or mid-conversion aborts the operation immediately; no partial results are kept.

Scan FSM, states S_IDLE, S_REQ, S_WAIT:
- S_IDLE: waits for eoc_in = 1, then goes to S_REQ.
- S_REQ: lasts one cycle. den_out = 1, daddr_out = CH_ADDR_LIST[idx]. Next state S_WAIT.
- S_WAIT: on drdy_in = 1, store code[idx] = do_in[15:4], set ch_valid[idx], advance idx (NUM_CH-1 wraps to 0), go to S_IDLE.
- S_WAIT timeout: if drdy_in has not arrived after DRDY_TIMEOUT cycles, set drp_timeout, leave idx unchanged, go to S_IDLE.
- eoc_in is ignored outside S_IDLE; it is not queued.
- daddr_out holds its value between requests.

Refresh and conversion:
- A tick is generated every CLK_HZ/REFRESH_HZ cycles; the counter is free-running.
- A tick is accepted only if the converter is idle, hold = 0 and ch_valid[sel] = 1. Otherwise it is dropped and digits_out is held.
- Cycle 0 (tick): latch code c = code[sel].
- Cycle 1:
  - If c >= 4093: value = FULL_SCALE_UV, overrange = 1.
  - Else: value = (c * FULL_SCALE_UV) >> 12, truncated, overrange = 0.
  - Product width = 12 + clog2(FULL_SCALE_UV+1).
- Cycles 2 .. B+1: bin2bcd_seq runs B shift/add-3 iterations, where B = clog2(FULL_SCALE_UV+1) (20 with defaults).
- Cycle B+2: digits_out is registered and digits_valid pulses. Tick-to-pulse latency is B+2 cycles (22 with defaults).
- If sel changes mid-conversion, the result is for the latched channel; the new sel takes effect at the next tick.
- If a code write to the converting channel coincides with cycle 0, the pre-write code is latched.

Decomposition:
- Package xadc_pkg: ADC_CODE_W = 12, DRP_ADDR_W = 7, the scan-state enum, and the overrange threshold 4093.
- Sub-module bin2bcd_seq:
  - Parameters BIN_W and NUM_DIGITS.
  - Ports: start, bin, busy, done, bcd.
  - Iterative double-dabble, one bit per cycle.
  - Reused later by the temperature display.

Test Plan:
- Bench uses CLK_HZ=1000, REFRESH_HZ=10 (tick every 100 cycles).
- Scan order: 5 eoc_in pulses with drdy_in 3 cycles after each den_out -> daddr_out at den_out is 0x12, 0x13, 0x1a, 0x1b, 0x12; ch_valid = 4'hF after the 4th read.
- Midscale: channel 0 do_in = 0x8000, sel = 0 -> digits_out = 0x0500000, overrange = 0, digits_valid 22 cycles after the tick.
- Clamp and LSB: do_in = 0xFFD0 (code 4093) -> 0x1000000, overrange = 1. do_in = 0x0010 (code 1) -> 0x0000244.
- Timeout: withhold drdy_in after den_out -> drp_timeout = 1 after 255 cycles; the next eoc_in re-reads the same address.
- Hold/invalid: hold = 1 or sel pointing at a channel with ch_valid = 0 -> no digits_valid across 3 ticks and digits_out unchanged. Releasing hold -> update on the next tick.
- Reset: assert CPU_RESETN = 0 at cycle 10 of a conversion -> all outputs return to reset values at once; no digits_valid after release until a new tick and read.
